eth_rx_hdr_filter: RTL and testbench

- Sits directly downstream of the 1G RGMII MAC RX FIFO output, in the logic clock domain.
- Consumes the 8-bit AXI-stream frame, strips the 14-byte Ethernet header and presents it as parallel fields on a valid/ready header interface.
- Forwards the payload on an AXI stream.
- Drops frames whose destination MAC fails the address filter, and drops runt frames.

---
 rtl/eth_rx_hdr_filter.sv | 202 ++++++++++++++++++++
 tb/tb_eth_rx_hdr_filter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_hdr_filter.sv
// Ethernet RX header parser and destination filter.
// Takes the byte stream from the RX FIFO and strips the 14-byte Ethernet
// header, which it presents as parallel fields on a valid/ready interface.
// It forwards the payload through a single output register. Frames whose
// destination fails the address filter are discarded, and so are runt frames.
//
// Ports:
//   clk, rst                       block clock, synchronous active-high reset
//   s_axis_*                       input frame stream (tuser = bad-frame marker)
//   m_eth_hdr_valid/ready          header handshake
//   m_eth_dest_mac/src_mac/type    header fields, first wire byte in the MSBs
//   m_eth_payload_axis_*           payload stream (tuser copied from input)
//   local_mac, promisc             filter controls, sampled at header end
//   busy                           parser not idle
//   error_header_early_termination pulse: tlast seen inside the header
//   stat_filter_drop               pulse: frame rejected by address filter
module eth_rx_hdr_filter #(
    parameter bit BROADCAST_ENABLE = 1'b1,
    parameter bit MULTICAST_ENABLE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,

    output logic        m_eth_hdr_valid,
    input  logic        m_eth_hdr_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,

    output logic [7:0]  m_eth_payload_axis_tdata,
    output logic        m_eth_payload_axis_tvalid,
    input  logic        m_eth_payload_axis_tready,
    output logic        m_eth_payload_axis_tlast,
    output logic        m_eth_payload_axis_tuser,

    input  logic [47:0] local_mac,
    input  logic        promisc,

    output logic        busy,
    output logic        error_header_early_termination,
    output logic        stat_filter_drop
);

    localparam int unsigned HDR_BYTES = 14;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned SR_W      = 8 * (HDR_BYTES - 1);
    localparam int unsigned HDR_W     = 8 * HDR_BYTES;
    localparam logic [CNT_W-1:0] LAST_HDR_IDX = CNT_W'(HDR_BYTES - 1);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [HDR_W-1:0]  hdr_full;
    logic [47:0]       dest_in;
    logic              filter_pass;
    logic              xfer;

    logic              hdr_valid_d;
    logic [47:0]       dest_d, src_d;
    logic [15:0]       type_d;
    logic [7:0]        pl_data_d;
    logic              pl_valid_d, pl_last_d, pl_user_d;
    logic              err_d, drop_d;

    // Header as it stands when the final header byte is on the input bus
    assign hdr_full = {sr_q, s_axis_tdata};
    assign dest_in  = hdr_full[HDR_W-1 -: 48];

    // Address filter; dest_in[40] is the I/G bit of the first wire byte
    assign filter_pass = promisc
                      || (dest_in == local_mac)
                      || (BROADCAST_ENABLE && (&dest_in))
                      || (MULTICAST_ENABLE && dest_in[40]);

    assign busy = (state_q != IDLE);

    // Next-state, datapath and input-ready logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        hdr_valid_d = m_eth_hdr_valid && !m_eth_hdr_ready;
        dest_d      = m_eth_dest_mac;
        src_d       = m_eth_src_mac;
        type_d      = m_eth_type;
        pl_valid_d  = m_eth_payload_axis_tvalid && !m_eth_payload_axis_tready;
        pl_data_d   = m_eth_payload_axis_tdata;
        pl_last_d   = m_eth_payload_axis_tlast;
        pl_user_d   = m_eth_payload_axis_tuser;
        err_d       = 1'b0;
        drop_d      = 1'b0;
        s_axis_tready = 1'b0;

        unique case (state_q)
            IDLE, HDR: s_axis_tready = !m_eth_hdr_valid;
            PAYLOAD:   s_axis_tready = m_eth_payload_axis_tready || !m_eth_payload_axis_tvalid;
            DROP:      s_axis_tready = 1'b1;
            default:   s_axis_tready = 1'b0;
        endcase

        xfer = s_axis_tvalid && s_axis_tready;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    sr_d = {sr_q[SR_W-9:0], s_axis_tdata};
                    if (s_axis_tlast) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (xfer) begin
                    sr_d = {sr_q[SR_W-9:0], s_axis_tdata};
                    if (s_axis_tlast) begin
                        // Includes tlast on the final header byte: zero payload is a runt
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == LAST_HDR_IDX) begin
                        cnt_d = '0;
                        if (filter_pass) begin
                            hdr_valid_d = 1'b1;
                            dest_d      = dest_in;
                            src_d       = hdr_full[HDR_W-49 -: 48];
                            type_d      = hdr_full[15:0];
                            state_d     = PAYLOAD;
                        end else begin
                            drop_d  = 1'b1;
                            state_d = DROP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    pl_valid_d = 1'b1;
                    pl_data_d  = s_axis_tdata;
                    pl_last_d  = s_axis_tlast;
                    pl_user_d  = s_axis_tuser;
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (xfer && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                        <= IDLE;
            cnt_q                          <= '0;
            sr_q                           <= '0;
            m_eth_hdr_valid                <= 1'b0;
            m_eth_dest_mac                 <= '0;
            m_eth_src_mac                  <= '0;
            m_eth_type                     <= '0;
            m_eth_payload_axis_tdata       <= '0;
            m_eth_payload_axis_tvalid      <= 1'b0;
            m_eth_payload_axis_tlast       <= 1'b0;
            m_eth_payload_axis_tuser       <= 1'b0;
            error_header_early_termination <= 1'b0;
            stat_filter_drop               <= 1'b0;
        end else begin
            state_q                        <= state_d;
            cnt_q                          <= cnt_d;
            sr_q                           <= sr_d;
            m_eth_hdr_valid                <= hdr_valid_d;
            m_eth_dest_mac                 <= dest_d;
            m_eth_src_mac                  <= src_d;
            m_eth_type                     <= type_d;
            m_eth_payload_axis_tdata       <= pl_data_d;
            m_eth_payload_axis_tvalid      <= pl_valid_d;
            m_eth_payload_axis_tlast       <= pl_last_d;
            m_eth_payload_axis_tuser       <= pl_user_d;
            error_header_early_termination <= err_d;
            stat_filter_drop               <= drop_d;
        end
    end

endmodule

// File: tb/tb_eth_rx_hdr_filter.sv
// Directed bench for eth_rx_hdr_filter: filter vector table plus sequences
// for runts, header backpressure, payload backpressure and mid-frame reset.
module tb_eth_rx_hdr_filter;

    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC   = 48'h02_00_00_00_00_02;
    localparam logic [15:0] ETYPE = 16'h0800;
    localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic        hdr_valid, hdr_ready;
    logic [47:0] dest_mac, src_mac;
    logic [15:0] eth_type;
    logic [7:0]  pl_tdata;
    logic        pl_tvalid, pl_tlast, pl_tuser;
    logic        pl_ready = 1'b1;
    logic        pl_toggle = 1'b0;
    logic [47:0] local_mac;
    logic        promisc;
    logic        busy, err_pulse, drop_pulse;

    eth_rx_hdr_filter #(
        .BROADCAST_ENABLE(1'b1),
        .MULTICAST_ENABLE(1'b0)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .s_axis_tdata                   (s_tdata),
        .s_axis_tvalid                  (s_tvalid),
        .s_axis_tready                  (s_tready),
        .s_axis_tlast                   (s_tlast),
        .s_axis_tuser                   (s_tuser),
        .m_eth_hdr_valid                (hdr_valid),
        .m_eth_hdr_ready                (hdr_ready),
        .m_eth_dest_mac                 (dest_mac),
        .m_eth_src_mac                  (src_mac),
        .m_eth_type                     (eth_type),
        .m_eth_payload_axis_tdata       (pl_tdata),
        .m_eth_payload_axis_tvalid      (pl_tvalid),
        .m_eth_payload_axis_tready      (pl_ready),
        .m_eth_payload_axis_tlast       (pl_tlast),
        .m_eth_payload_axis_tuser       (pl_tuser),
        .local_mac                      (local_mac),
        .promisc                        (promisc),
        .busy                           (busy),
        .error_header_early_termination (err_pulse),
        .stat_filter_drop               (drop_pulse)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Payload ready: held at 1 or toggled every cycle
    always begin
        @(posedge clk);
        #1;
        pl_ready = pl_toggle ? ~pl_ready : 1'b1;
    end

    // Output monitor, sampled mid-cycle
    logic [7:0]   pl_q[$];
    logic [1:0]   pl_lu_q[$];
    logic [111:0] hdr_q[$];
    int           err_cnt = 0;
    int           drop_cnt = 0;
    int           unstable = 0;
    int           stall_cycles = 0;
    logic [111:0] prev_hdr = '0;
    logic         prev_hold = 1'b0;
    logic [111:0] cur_hdr;
    assign cur_hdr = {dest_mac, src_mac, eth_type};

    always @(negedge clk) begin
        if (!rst) begin
            if (pl_tvalid && pl_ready) begin
                pl_q.push_back(pl_tdata);
                pl_lu_q.push_back({pl_tlast, pl_tuser});
            end
            if (hdr_valid && hdr_ready) hdr_q.push_back(cur_hdr);
            if (err_pulse) err_cnt++;
            if (drop_pulse) drop_cnt++;
            if (prev_hold && (cur_hdr !== prev_hdr)) unstable++;
        end
        prev_hold = !rst && hdr_valid && !hdr_ready;
        prev_hdr  = cur_hdr;
    end

    task automatic clear_mon();
        pl_q.delete();
        pl_lu_q.delete();
        hdr_q.delete();
        err_cnt = 0;
        drop_cnt = 0;
        stall_cycles = 0;
    endtask

    // Called just after a rising edge; returns just after the transfer edge
    task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        stall_cycles += n;
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: actual=stalled required=tready");
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    // Frame of 14+plen bytes (plen<0 gives a runt); payload byte k=(k+1)*step.
    // stop_at>=0 sends only that many bytes and leaves the frame open.
    task automatic send_frame(input logic [47:0] dest, input int plen, input int step,
                              input logic ulast, input int stop_at);
        logic [111:0] h;
        logic [7:0]   b;
        int           nbytes;
        int           total;
        h = {dest, SRC, ETYPE};
        nbytes = 14 + plen;
        total = (stop_at >= 0) ? stop_at : nbytes;
        for (int i = 0; i < total; i++) begin
            b = (i < 14) ? h[111 - 8*i -: 8] : 8'((i - 13) * step);
            send_byte(b, i == nbytes - 1, (i == nbytes - 1) && ulast);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_good_frame(input string tag, input logic [47:0] dest);
        check({tag, "_hdr_count"}, 64'(hdr_q.size()), 64'd1);
        if (hdr_q.size() == 1) begin
            check({tag, "_dest"}, 64'(hdr_q[0][111:64]), 64'(dest));
            check({tag, "_src"},  64'(hdr_q[0][63:16]),  64'(SRC));
            check({tag, "_type"}, 64'(hdr_q[0][15:0]),   64'(ETYPE));
        end
        check({tag, "_pl_count"}, 64'(pl_q.size()), 64'd4);
        if (pl_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check({tag, "_pl_data"}, 64'(pl_q[k]), 64'(8'((k + 1) * 17)));
                check({tag, "_pl_last_user"}, 64'(pl_lu_q[k]), (k == 3) ? 64'd2 : 64'd0);
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [47:0] dest;
        logic        promisc;
        int          exp_hdr;
        int          exp_drop;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"exact_match", LOCAL,                  1'b0, 1, 0};
        vecs[1] = '{"mismatch",    48'h02_00_00_00_00_09,  1'b0, 0, 1};
        vecs[2] = '{"promisc",     48'h02_00_00_00_00_09,  1'b1, 1, 0};
        vecs[3] = '{"broadcast",   BCAST,                  1'b0, 1, 0};
        vecs[4] = '{"multicast",   48'h01_00_5e_00_00_01,  1'b0, 0, 1};

        rst = 1'b1;
        s_tdata = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        hdr_ready = 1'b1;
        local_mac = LOCAL;
        promisc = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", 64'({hdr_valid, pl_tvalid, pl_tlast, pl_tuser, busy, err_pulse, drop_pulse}), 64'd0);
        check("rst_dest", 64'(dest_mac), 64'd0);
        check("rst_src", 64'(src_mac), 64'd0);
        check("rst_type_data", 64'({eth_type, pl_tdata}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Address filter table
        for (int v = 0; v < 5; v++) begin
            promisc = vecs[v].promisc;
            clear_mon();
            send_frame(vecs[v].dest, 4, 17, 1'b0, -1);
            settle(4);
            check({vecs[v].name, "_drop_pulses"}, 64'(drop_cnt), 64'(vecs[v].exp_drop));
            check({vecs[v].name, "_err_pulses"}, 64'(err_cnt), 64'd0);
            check({vecs[v].name, "_stall"}, 64'(stall_cycles), 64'd0);
            check({vecs[v].name, "_busy"}, 64'(busy), 64'd0);
            if (vecs[v].exp_hdr == 1) begin
                check_good_frame(vecs[v].name, vecs[v].dest);
            end else begin
                check({vecs[v].name, "_hdr_count"}, 64'(hdr_q.size()), 64'd0);
                check({vecs[v].name, "_pl_count"}, 64'(pl_q.size()), 64'd0);
            end
        end
        promisc = 1'b0;

        // Runts: tlast on byte 9, then on byte 13
        clear_mon();
        send_frame(LOCAL, -4, 17, 1'b0, -1);
        settle(3);
        check("runt10_err", 64'(err_cnt), 64'd1);
        check("runt10_out", 64'({32'(hdr_q.size()), 32'(pl_q.size())}), 64'd0);
        check("runt10_busy", 64'(busy), 64'd0);
        clear_mon();
        send_frame(LOCAL, 0, 17, 1'b0, -1);
        settle(3);
        check("runt14_err", 64'(err_cnt), 64'd1);
        check("runt14_out", 64'({32'(hdr_q.size()), 32'(pl_q.size())}), 64'd0);
        check("runt14_drop", 64'(drop_cnt), 64'd0);
        check("runt14_busy", 64'(busy), 64'd0);

        // Header backpressure: second frame waits at byte 0
        clear_mon();
        hdr_ready = 1'b0;
        send_frame(LOCAL, 4, 17, 1'b0, -1);
        fork
            send_frame(BCAST, 4, 17, 1'b0, -1);
            begin
                repeat (10) @(negedge clk);
                check("b2b_stall_tready", 64'(s_tready), 64'd0);
                check("b2b_stall_busy", 64'(busy), 64'd0);
                check("b2b_stall_hdr_valid", 64'(hdr_valid), 64'd1);
                check("b2b_stall_dest", 64'(dest_mac), 64'(LOCAL));
                check("b2b_first_payload", 64'(pl_q.size()), 64'd4);
                @(posedge clk);
                #1;
                hdr_ready = 1'b1;
            end
        join
        settle(4);
        check("b2b_hdr_count", 64'(hdr_q.size()), 64'd2);
        if (hdr_q.size() == 2) begin
            check("b2b_hdr0_dest", 64'(hdr_q[0][111:64]), 64'(LOCAL));
            check("b2b_hdr1_dest", 64'(hdr_q[1][111:64]), 64'(BCAST));
        end
        check("b2b_stable", 64'(unstable), 64'd0);
        check("b2b_pl_count", 64'(pl_q.size()), 64'd8);

        // Payload backpressure: 46 bytes, tuser on the last
        clear_mon();
        pl_toggle = 1'b1;
        send_frame(LOCAL, 46, 1, 1'b1, -1);
        settle(6);
        check("toggle_hdr_count", 64'(hdr_q.size()), 64'd1);
        check("toggle_pl_count", 64'(pl_q.size()), 64'd46);
        if (pl_q.size() == 46) begin
            for (int k = 0; k < 46; k++) begin
                check("toggle_pl_data", 64'(pl_q[k]), 64'(8'(k + 1)));
                check("toggle_last_user", 64'(pl_lu_q[k]), (k == 45) ? 64'd3 : 64'd0);
            end
        end

        // Reset after payload byte 20, then a fresh frame
        send_frame(LOCAL, 46, 1, 1'b0, 14 + 20);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_flags", 64'({hdr_valid, pl_tvalid, pl_tlast, busy}), 64'd0);
        check("midrst_data", 64'({pl_tdata, eth_type}), 64'd0);
        check("midrst_dest", 64'(dest_mac), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pl_toggle = 1'b0;
        clear_mon();
        send_frame(LOCAL, 4, 17, 1'b0, -1);
        settle(4);
        check_good_frame("after_rst", LOCAL);
        check("after_rst_err", 64'(err_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
